zl_rs_checker: RTL and testbench
================================

Name: zl_rs_checker

Overview:
- Receive-side counterpart to the RS encoder. Accepts one N-symbol codeword at a time, one symbol per clock.
- Forwards the K message symbols downstream and consumes the N-K check symbols.
- Computes the N-K syndromes by Horner evaluation and reports pass/fail once per codeword.
- Sits after the deinterleaver in the receive chain. It detects errors only; it does not correct them.

Parameters:
N, 0, codeword length in symbols; must satisfy N <= 2^M-1 and must be overridden
K, 0, message length in symbols; K < N
M, 0, symbol width in bits
Roots, 0, packed generator roots, M*(N-K) bits; root i is at bits [M*(i+1)-1 -: M]
Gf_poly, 0, GF(2^M) field polynomial, passed to zl_gf_mul

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
data_in_req  input  1  upstream symbol valid
data_in_ack  output  1  upstream symbol accepted
data_in  input  M  received symbol; first symbol of the codeword is the highest-order coefficient
data_out_req  output  1  message symbol valid
data_out_ack  input  1  downstream accepts
data_out  output  M  message symbol
chk_valid  output  1  one-cycle pulse at codeword end
chk_err  output  1  1 = at least one syndrome nonzero; valid while chk_valid=1
syndromes  output  M*(N-K)  final syndromes, packed like Roots; held until the next codeword completes
err_cnt  output  16  codeword error count (see Optional Feature)

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low forces all state to reset immediately.
- Reset values: sym_cnt=0, syndromes=0, chk_valid=0, chk_err=0, err_cnt=0.
- Transfer rule: a symbol moves when data_in_req && data_in_ack.
- is_data = (sym_cnt < K).
- Handshake:
  - data_out_req = data_in_req && is_data.
  - data_out = data_in, with zero added latency.
  - data_in_ack = is_data ? data_out_ack : 1. Check symbols are consumed unconditionally, at one per cycle while data_in_req is high.
- sym_cnt (M bits):
  - Increments on each transfer.
  - At N-1, a transfer wraps it to 0.
  - Holds when there is no transfer.
- Syndrome accumulators acc[i], i = 0..N-K-1, updated on each transfer:
  - nxt[i] = gf_mul(base[i], Roots[i]) ^ data_in, where base[i] = (sym_cnt==0) ? 0 : acc[i].
  - acc[i] <= nxt[i].
  - One zl_gf_mul instance per root. Constant-operand multipliers are acceptable.
- Codeword end (transfer with sym_cnt==N-1):
  - syndromes <= nxt (packed).
  - chk_err <= |nxt.
  - chk_valid <= 1 for exactly the next cycle, otherwise 0.
  - chk_err holds its value between pulses.
- No backpressure on status: chk_valid is a pulse and is never stalled.
- The first symbol of the next codeword may transfer in the same cycle that chk_valid is high. acc restarts via the sym_cnt==0 select; it needs no explicit clear.
- Stalls:
  - data_in_req low: all state holds.
  - data_out_ack low during the data phase: all state holds, and data_out_req remains asserted while data_in_req is high.
- Reset mid-codeword: the partial codeword is discarded, no chk_valid is produced, and the next accepted symbol is treated as symbol 0.
- No framing input. Alignment is established purely by count from reset.

Optional Feature:
- Macro: ZL_RS_CHECKER_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on each chk_valid pulse where chk_err=1.
  - err_cnt saturates at 16'hFFFF.
  - err_cnt is cleared only by reset.
- Undefined: err_cnt is tied to 0 and no counter register is synthesised. The port is always present.

Test Plan:
All tests use N=204, K=188, M=8, Gf_poly=285, Roots = alpha^0..alpha^15 (alpha=2), matching the DVB-S encoder configuration.
1. All-zero codeword, 204 zeros, data_in_req and data_out_ack held high -> 188 outputs of 0x00. chk_valid pulses once, one cycle after symbol 203. chk_err=0, syndromes=0.
2. zl_rs_encoder output for message 0x00..0xBB fed in -> data_out reproduces 0x00..0xBB in order. chk_err=0, all syndromes 0.
3. Same codeword with symbol 5 XORed by 0x01 -> chk_err=1 and syndrome 0 = 0x01. With the macro defined, err_cnt=1 after the pulse.
4. Random data_out_ack deasserts (~50%) during the data phase with data_ack held low across the K boundary:
   - No message symbol is lost or duplicated.
   - The 16 check symbols are accepted at one per cycle with data_out_req=0.
   - Result matches test 2.
5. Back-to-back codewords with no idle gap, codewords 2 then 3 -> chk_valid pulses 204 cycles apart. chk_err values are 0 then 1. syndromes update only on the pulses.
6. rst_n asserted at symbol 100, then a clean codeword is sent -> no chk_valid for the aborted codeword. The following codeword produces chk_err=0, and err_cnt is reset to 0.

Source files
------------

// File: rtl/zl_rs_checker.sv
// zl_rs_checker: receive-side Reed-Solomon syndrome checker.
//   Takes one N-symbol codeword per pass, one symbol per transfer. The first
//   symbol received is the highest-order coefficient. The K message symbols are
//   passed straight through to downstream with no added latency. The N-K check
//   symbols are consumed without any backpressure. Each syndrome is built by
//   Horner evaluation at one generator root. At the end of every codeword the
//   block reports pass/fail. It detects errors only; it does not correct them.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   data_in_req/ack/data_in    upstream symbol stream
//   data_out_req/ack/data_out  downstream message-symbol stream
//   chk_valid                  one-cycle pulse after the last codeword symbol
//   chk_err                    1 = some syndrome was nonzero (held between pulses)
//   syndromes                  final syndromes, packed like Roots, held between pulses
//   err_cnt                    saturating count of failed codewords
//
// Build option: define ZL_RS_CHECKER_ERR_CNT_EN to implement err_cnt.
// Without it, err_cnt is tied to zero.

module zl_gf_mul #(
  parameter int unsigned M       = 8,
  parameter int unsigned Gf_poly = 285
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] p_o
);
  localparam logic [M-1:0] POLY = Gf_poly[M-1:0];

  // Shift-and-add multiply. The field polynomial is folded in on every shift.
  always_comb begin
    logic [M-1:0] aa;
    aa  = a_i;
    p_o = '0;
    for (int unsigned k = 0; k < M; k++) begin
      if (b_i[k]) p_o = p_o ^ aa;
      aa = aa[M-1] ? ((aa << 1) ^ POLY) : (aa << 1);
    end
  end
endmodule

module zl_rs_checker #(
  parameter int unsigned              N       = 0,
  parameter int unsigned              K       = 0,
  parameter int unsigned              M       = 0,
  parameter logic [M*(N-K)-1:0]       Roots   = '0,
  parameter int unsigned              Gf_poly = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in_req,
  output logic                 data_in_ack,
  input  logic [M-1:0]         data_in,
  output logic                 data_out_req,
  input  logic                 data_out_ack,
  output logic [M-1:0]         data_out,
  output logic                 chk_valid,
  output logic                 chk_err,
  output logic [M*(N-K)-1:0]   syndromes,
  output logic [15:0]          err_cnt
);
  localparam int unsigned R    = N - K;
  localparam int unsigned LAST = N - 1;

  logic [M-1:0]   sym_cnt_q, sym_cnt_d;
  logic [M*R-1:0] acc_q, acc_d;
  logic [M*R-1:0] syn_q, syn_d;
  logic [M*R-1:0] nxt;
  logic           chk_valid_q, chk_valid_d;
  logic           chk_err_q, chk_err_d;
  logic           is_data, is_first, is_last, xfer;

  assign is_data  = (32'(sym_cnt_q) < K);
  assign is_first = (sym_cnt_q == '0);
  assign is_last  = (32'(sym_cnt_q) == LAST);

  // Message symbols follow downstream backpressure. Check symbols are always taken.
  assign data_out_req = data_in_req && is_data;
  assign data_out     = data_in;
  assign data_in_ack  = is_data ? data_out_ack : 1'b1;
  assign xfer         = data_in_req && data_in_ack;

  // On symbol 0 the accumulator input is forced to zero. This makes an explicit
  // clear unnecessary, so back-to-back codewords work without a gap.
  for (genvar i = 0; i < R; i++) begin : g_syn
    logic [M-1:0] base, prod;
    assign base = is_first ? '0 : acc_q[M*(i+1)-1 -: M];
    zl_gf_mul #(.M(M), .Gf_poly(Gf_poly)) u_mul (
      .a_i (base),
      .b_i (Roots[M*(i+1)-1 -: M]),
      .p_o (prod)
    );
    assign nxt[M*(i+1)-1 -: M] = prod ^ data_in;
  end

  always_comb begin
    sym_cnt_d   = sym_cnt_q;
    acc_d       = acc_q;
    syn_d       = syn_q;
    chk_err_d   = chk_err_q;
    chk_valid_d = 1'b0;
    if (xfer) begin
      acc_d = nxt;
      if (is_last) begin
        sym_cnt_d   = '0;
        syn_d       = nxt;
        chk_err_d   = |nxt;
        chk_valid_d = 1'b1;
      end else begin
        sym_cnt_d = sym_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q   <= '0;
      acc_q       <= '0;
      syn_q       <= '0;
      chk_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      sym_cnt_q   <= sym_cnt_d;
      acc_q       <= acc_d;
      syn_q       <= syn_d;
      chk_valid_q <= chk_valid_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign chk_valid = chk_valid_q;
  assign chk_err   = chk_err_q;
  assign syndromes = syn_q;

`ifdef ZL_RS_CHECKER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (chk_valid_q && chk_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_zl_rs_checker.sv
// Testbench for zl_rs_checker in the DVB-S configuration: RS(204,188) over
// GF(256) with field polynomial 0x11D and roots alpha^0..alpha^15.
module tb_zl_rs_checker;
  localparam int unsigned N = 204;
  localparam int unsigned K = 188;
  localparam int unsigned M = 8;
  localparam int unsigned R = N - K;
  localparam logic [127:0] ROOTS = 128'h2613_87cd_e874_3a1d_8040_2010_0804_0201;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         data_in_req = 1'b0;
  logic         data_in_ack;
  logic [7:0]   data_in = '0;
  logic         data_out_req;
  logic         data_out_ack = 1'b0;
  logic [7:0]   data_out;
  logic         chk_valid;
  logic         chk_err;
  logic [127:0] syndromes;
  logic [15:0]  err_cnt;

  zl_rs_checker #(.N(N), .K(K), .M(M), .Roots(ROOTS), .Gf_poly(285)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_in      (data_in),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .data_out     (data_out),
    .chk_valid    (chk_valid),
    .chk_err      (chk_err),
    .syndromes    (syndromes),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           gexp [255];
  int           glog [256];
  int           gpoly [R+1];
  logic [7:0]   cw [N];
  logic [7:0]   cw2 [N];
  logic [7:0]   rx [N];
  logic [7:0]   outq [$];
  int           pulse_cyc [$];
  int           mpos = 0;
  int           cyc = 0;
  bit           exp_valid = 1'b0;
  bit           exp_err = 1'b0;
  logic [127:0] exp_syn = '0;
  logic [15:0]  exp_cnt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(gexp[(glog[a] + glog[b]) % 255]);
  endfunction

  // Direct evaluation S_i = sum_j rx[j] * alpha^(i*(N-1-j)).
  function automatic logic [127:0] model_syn();
    logic [127:0] s;
    logic [7:0]   acc;
    s = '0;
    for (int i = 0; i < R; i++) begin
      acc = '0;
      for (int j = 0; j < N; j++) acc ^= gmul(rx[j], 8'(gexp[(i * (N - 1 - j)) % 255]));
      s[8*i +: 8] = acc;
    end
    return s;
  endfunction

  // Systematic encoder: the check symbols are the remainder of m(x)*x^16 mod g(x).
  task automatic encode_seq();
    logic [7:0] rem [R];
    logic [7:0] fb;
    for (int k = 0; k < R; k++) rem[k] = '0;
    for (int j = 0; j < K; j++) begin
      cw2[j] = 8'(j);
      fb = cw2[j] ^ rem[R-1];
      for (int k = R - 1; k > 0; k--) rem[k] = rem[k-1] ^ gmul(fb, 8'(gpoly[k]));
      rem[0] = gmul(fb, 8'(gpoly[0]));
    end
    for (int t = 0; t < R; t++) cw2[K+t] = rem[R-1-t];
  endtask

  task automatic step(input bit req, input logic [7:0] d, input bit ack, output bit moved);
    bit isd;
    @(negedge clk);
    data_in_req = req; data_in = d; data_out_ack = ack;
    #1;
    isd = (mpos < K);
    chk("data_out_req", data_out_req, req && isd);
    chk("data_in_ack", data_in_ack, isd ? ack : 1'b1);
    if (req && isd) chk("data_out", data_out, d);
    chk("chk_valid", chk_valid, exp_valid);
    chk("chk_err", chk_err, exp_err);
    chk("syndromes", syndromes, exp_syn);
    chk("err_cnt", err_cnt, exp_cnt);
    if (chk_valid === 1'b1) pulse_cyc.push_back(cyc);
    moved = req && (isd ? ack : 1'b1);
    if (moved && isd) outq.push_back(data_out);
    @(posedge clk);
    cyc++;
`ifdef ZL_RS_CHECKER_ERR_CNT_EN
    if (exp_valid && exp_err && exp_cnt != 16'hFFFF) exp_cnt++;
`endif
    exp_valid = 1'b0;
    if (moved) begin
      rx[mpos] = d;
      if (mpos == N - 1) begin
        exp_syn = model_syn(); exp_err = |exp_syn; exp_valid = 1'b1; mpos = 0;
      end else mpos++;
    end
  endtask

  task automatic send_cw(input bit rand_ack, input int stop_at);
    int j = 0; int guard = 0; int hold = 0; bit a; bit mv;
    outq.delete();
    while (j < stop_at && guard < 3000) begin
      if (j < K) begin
        a = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
        // Hold downstream off across the message/check boundary.
        if (rand_ack && j == K - 1 && hold < 3) begin a = 1'b0; hold++; end
      end else a = rand_ack ? 1'b0 : 1'b1;
      step(1'b1, cw[j], a, mv);
      if (mv) j++;
      guard++;
    end
    chk("send_progress", 128'(j), 128'(stop_at));
    if (stop_at == N) begin
      chk("out_count", 128'(outq.size()), 128'(K));
      for (int i = 0; i < K && i < outq.size(); i++) chk("out_order", outq[i], cw[i]);
    end
  endtask

  task automatic idle(input int n);
    bit mv;
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), mv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_in_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_chk_valid", chk_valid, 1'b0);
    chk("rst_chk_err", chk_err, 1'b0);
    chk("rst_syndromes", syndromes, '0);
    chk("rst_err_cnt", err_cnt, '0);
    mpos = 0; exp_valid = 1'b0; exp_err = 1'b0; exp_syn = '0; exp_cnt = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int x; int p;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x; glog[x] = i;
      x = x << 1; if (x & 256) x ^= 285;
    end
    glog[0] = 0;
    for (int k = 0; k <= R; k++) gpoly[k] = (k == 0) ? 1 : 0;
    for (int i = 0; i < R; i++)
      for (int k = R; k >= 0; k--)
        gpoly[k] = (k > 0 ? gpoly[k-1] : 0) ^ int'(gmul(8'(gpoly[k]), 8'(gexp[i])));
    encode_seq();

    // Reset state.
    #1;
    chk("reset_chk_valid", chk_valid, 1'b0);
    chk("reset_chk_err", chk_err, 1'b0);
    chk("reset_syndromes", syndromes, '0);
    chk("reset_err_cnt", err_cnt, '0);
    @(negedge clk); #2 rst_n = 1'b1;
    idle(3);

    // 1: all-zero codeword.
    for (int j = 0; j < N; j++) cw[j] = '0;
    pulse_cyc.delete();
    send_cw(1'b0, N);
    idle(3);
    chk("t1_pulses", 128'(pulse_cyc.size()), 128'd1);
    chk("t1_chk_err", chk_err, 1'b0);
    chk("t1_syndromes", syndromes, '0);

    // 2: encoded message 0x00..0xBB.
    cw = cw2;
    send_cw(1'b0, N);
    idle(2);
    chk("t2_chk_err", chk_err, 1'b0);
    chk("t2_syndromes", syndromes, '0);

    // 3: single-bit error in symbol 5.
    cw[5] = cw[5] ^ 8'h01;
    send_cw(1'b0, N);
    idle(2);
    chk("t3_chk_err", chk_err, 1'b1);
    chk("t3_syn0", syndromes[7:0], 8'h01);
`ifdef ZL_RS_CHECKER_ERR_CNT_EN
    chk("t3_err_cnt", err_cnt, 16'd1);
`else
    chk("t3_err_cnt", err_cnt, 16'd0);
`endif

    // 4: random downstream backpressure.
    cw = cw2;
    send_cw(1'b1, N);
    idle(2);
    chk("t4_chk_err", chk_err, 1'b0);
    chk("t4_syndromes", syndromes, '0);

    // 5: back-to-back clean then corrupted codeword.
    pulse_cyc.delete();
    send_cw(1'b0, N);
    cw[5] = cw[5] ^ 8'h01;
    send_cw(1'b0, N);
    idle(2);
    chk("t5_pulses", 128'(pulse_cyc.size()), 128'd2);
    p = (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1;
    chk("t5_spacing", 128'(p), 128'd204);
    chk("t5_chk_err", chk_err, 1'b1);

    // 6: reset at symbol 100, then a clean codeword.
    cw = cw2;
    send_cw(1'b0, 100);
    do_reset();
    pulse_cyc.delete();
    send_cw(1'b0, N);
    idle(3);
    chk("t6_pulses", 128'(pulse_cyc.size()), 128'd1);
    chk("t6_chk_err", chk_err, 1'b0);
    chk("t6_err_cnt", err_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
